// File: rtl/instr_loader.sv
// instr_loader: fills the byte-addressed instruction memory from a
// length-prefixed byte stream and holds the core in reset while loading.
module instr_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        hdr_cnt;
    logic [31:0]       len;
    logic [ADDR_W-1:0] byte_cnt;
    logic              accept;
    logic [31:0]       hdr_len;
    logic              last_byte;

    assign accept    = rx_valid && rx_ready;
    // Full length as it stands once the 4th header byte arrives.
    assign hdr_len   = {rx_data, len[23:0]};
    assign last_byte = ({{(32-ADDR_W){1'b0}}, byte_cnt} == (len - 32'd1));

    // Status outputs decode straight from the state register.
    always_comb begin
        rx_ready  = (state == HDR) || (state == DATA);
        core_rst  = (state != DONE);
        load_done = (state == DONE);
        load_err  = (state == ERR);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured outside HDR/DATA.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR: begin
                if (accept && hdr_cnt == 2'd3) begin
                    if (hdr_len == 32'd0)               state_nxt = DONE;
                    else if (hdr_len > 32'(MEM_BYTES))  state_nxt = ERR;
                    else                                state_nxt = DATA;
                end
            end
            DATA: if (accept && last_byte) state_nxt = DONE;
            DONE: if (start) state_nxt = HDR;
            ERR:  if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, byte counter and the one-cycle-delayed memory write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt   <= '0;
            len       <= '0;
            byte_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if ((state == IDLE || state == DONE || state == ERR) && start) begin
                hdr_cnt <= '0;
            end
            if (state == HDR && accept) begin
                len[{hdr_cnt, 3'b000} +: 8] <= rx_data;
                hdr_cnt                     <= hdr_cnt + 2'd1;
                byte_cnt                    <= '0;
            end
            if (state == DATA && accept) begin
                mem_we    <= 1'b1;
                mem_addr  <= byte_cnt;
                mem_wdata <= rx_data;
                // Hold on the final byte so L == MEM_BYTES never wraps the counter.
                if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: per-cycle comparison against a
// behavioural model plus literal checks on each directed load.
module tb_instr_loader;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int failures = 0;

    instr_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 header, 2 payload, 3 done, 4 error
    int          m_phase = 0;
    int          m_hidx = 0;
    int unsigned m_len = 0;
    int          m_bidx = 0;
    logic [7:0]  m_hdr [4];
    bit          m_we = 0;
    int          m_addr = 0;
    int          m_data = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_hidx = 0; m_bidx = 0; m_len = 0;
            m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_hidx = 0; end
                1: if (rx_valid) begin
                    m_hdr[m_hidx] = rx_data;
                    m_hidx++;
                    if (m_hidx == 4) begin
                        m_len = m_hdr[0] + 256 * m_hdr[1] + 65536 * m_hdr[2]
                              + 16777216 * m_hdr[3];
                        if (m_len == 0)              m_phase = 3;
                        else if (m_len > MEM_BYTES)  m_phase = 4;
                        else begin m_phase = 2; m_bidx = 0; end
                    end
                end
                2: if (rx_valid) begin
                    m_we = 1; m_addr = m_bidx; m_data = rx_data;
                    m_bidx++;
                    if (m_bidx == int'(m_len)) m_phase = 3;
                end
                default: if (start) begin m_phase = 1; m_hidx = 0; end
            endcase
        end
    end

    // Per-cycle comparison and write tracking on the falling edge.
    int wr_cnt = 0;
    int last_wr_addr = -1;
    logic [7:0] dut_mem [MEM_BYTES];

    always @(negedge clk) begin
        chk("rx_ready",  32'(rx_ready),  32'(m_phase == 1 || m_phase == 2));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
        chk("core_rst",  32'(core_rst),  32'(m_phase != 3));
        chk("load_done", 32'(load_done), 32'(m_phase == 3));
        chk("load_err",  32'(load_err),  32'(m_phase == 4));
        if (mem_we) begin
            wr_cnt++;
            last_wr_addr = int'(mem_addr);
            dut_mem[mem_addr] = mem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        logic rr;
        bit ok;
        rx_valid = 1'b0;
        for (int g = 0; g < gaps; g++) cyc();
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); rr = rx_ready;
            @(posedge clk); #1;
            if (rr) ok = 1;
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_hdr(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], 0);
    endtask

    task automatic settle();
        rx_valid = 1'b0; cyc(); @(negedge clk); #1;
    endtask

    initial begin
        // Reset, then idle.
        repeat (2) cyc();
        rst = 1'b0;
        repeat (5) cyc();
        @(negedge clk); #1;
        chk("reset_core_rst", 32'(core_rst), 32'd1);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        chk("reset_mem_we",   32'(mem_we),   32'd0);

        // 4-byte load, valid held high.
        wr_cnt = 0; cyc();
        do_start();
        send_hdr(32'd4);
        send_byte(8'h13, 0); send_byte(8'h05, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t2_load_done_now", 32'(load_done), 32'd1);
        settle();
        chk("t2_writes", 32'(wr_cnt), 32'd4);
        chk("t2_last_addr", 32'(last_wr_addr), 32'd3);
        chk("t2_mem1", 32'(dut_mem[1]), 32'h05);
        chk("t2_core_rst", 32'(core_rst), 32'd0);

        // Full 1024-byte load with random gaps.
        wr_cnt = 0;
        do_start();
        send_hdr(32'd1024);
        for (int i = 0; i < 1024; i++)
            send_byte(8'(i) ^ 8'h5a, $urandom_range(0, 2));
        settle();
        chk("t3_writes", 32'(wr_cnt), 32'd1024);
        chk("t3_last_addr", 32'(last_wr_addr), 32'd1023);
        chk("t3_mem1023", 32'(dut_mem[1023]), 32'(8'hff ^ 8'h5a));
        chk("t3_load_done", 32'(load_done), 32'd1);

        // Oversize header, then recovery.
        wr_cnt = 0;
        do_start();
        send_hdr(32'd1025);
        settle();
        chk("t4_load_err", 32'(load_err), 32'd1);
        chk("t4_core_rst", 32'(core_rst), 32'd1);
        chk("t4_writes", 32'(wr_cnt), 32'd0);
        do_start();
        send_hdr(32'd1);
        send_byte(8'hab, 0);
        settle();
        chk("t4_err_clear", 32'(load_err), 32'd0);
        chk("t4_writes2", 32'(wr_cnt), 32'd1);
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_mem0", 32'(dut_mem[0]), 32'hab);

        // Zero length.
        wr_cnt = 0;
        do_start();
        send_hdr(32'd0);
        chk("t5_done_now", 32'(load_done), 32'd1);
        settle();
        chk("t5_writes", 32'(wr_cnt), 32'd0);
        chk("t5_core_rst", 32'(core_rst), 32'd0);

        // Async reset mid-load, with a write pending on the reset cycle.
        wr_cnt = 0;
        do_start();
        send_hdr(32'd16);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 0);
        rst = 1'b1; #1;
        chk("t6_we_dropped", 32'(mem_we), 32'd0);
        chk("t6_core_rst", 32'(core_rst), 32'd1);
        cyc(); rst = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hee;
        repeat (3) cyc();
        chk("t6_ready_low", 32'(rx_ready), 32'd0);
        settle();
        chk("t6_writes", 32'(wr_cnt), 32'd7);
        wr_cnt = 0;
        do_start();
        send_hdr(32'd2);
        send_byte(8'hc1, 0); send_byte(8'hc2, 0);
        settle();
        chk("t6_writes2", 32'(wr_cnt), 32'd2);
        chk("t6_mem0", 32'(dut_mem[0]), 32'hc1);
        chk("t6_mem1", 32'(dut_mem[1]), 32'hc2);
        chk("t6_done", 32'(load_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
